stream_escape_encoder: RTL and testbench
========================================

# stream_escape_encoder

Parametrised AXI-Stream byte-stuffing encoder for the Manchester TX path. It sits between the framing logic and the Manchester serializer. Any data word that equals the escape symbol or any entry of a configurable escaped-symbol list is replaced by a two-word sequence: `ESCAPE_SYMBOL`, then `data ^ XOR_MASK`. Compared with the first-generation escaper, it adds:
- an N-entry symbol list,
- XOR-based mapping,
- a runtime bypass,
- an escape counter,
- full one-word-per-cycle throughput for unescaped data.

## Interface
Parameters:
- `DATA_WIDTH`, 8, stream word width.
- `ESCAPE_SYMBOL`, 8'hE5, escape marker; always escaped itself.
- `NUM_ESCAPED`, 1, number of entries in `ESCAPED_LIST` (≥1).
- `ESCAPED_LIST`, {8'hD5}, packed `NUM_ESCAPED*DATA_WIDTH` list; entry i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `XOR_MASK`, 8'h20, applied to the second word of an escape pair (D5→F5, E5→C5).
- `COUNT_WIDTH`, 16, width of `escape_count`.

Ports:
- `aclk` in 1: clock; all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in DATA_WIDTH: input word.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: input end of frame.
- `m_axis_tdata` out DATA_WIDTH: output word, registered.
- `m_axis_tvalid` out 1: output valid, registered.
- `m_axis_tready` in 1: output ready.
- `m_axis_tlast` out 1: output end of frame, registered.
- `bypass` in 1: when 1, accepted words pass unmodified.
- `clear_count` in 1: synchronous clear of `escape_count`.
- `escape_count` out COUNT_WIDTH: saturating count of escape pairs emitted.

## Operation
- `match` = !bypass && (s_axis_tdata == ESCAPE_SYMBOL || s_axis_tdata equals any ESCAPED_LIST entry). Combinational compare over all entries.
- Output register holds one word. A pending register holds the second word of a pair plus its tlast.
- `out_free` = !m_axis_tvalid || m_axis_tready.
- FSM states: NORMAL, SECOND.
- `s_axis_tready` = (state == NORMAL) && out_free. Combinational, with no dependency on s_axis_tvalid.
- NORMAL, accept (tvalid && tready):
  - If match: output ← {ESCAPE_SYMBOL, tlast=0, valid=1}; pending ← {tdata ^ XOR_MASK, s_axis_tlast}; go to SECOND.
  - Else: output ← {tdata, s_axis_tlast, valid=1}; stay in NORMAL.
- NORMAL, no accept: if m_axis_tready, then m_axis_tvalid ← 0. Otherwise hold.
- SECOND (m_axis_tvalid is always 1 here):
  - If m_axis_tready: output ← {pending data, pending tlast, valid=1}; go to NORMAL.
  - Else hold all outputs.
- `bypass` is sampled only on the accept cycle. Changing it while in SECOND does not affect the pending word.
- tlast is never asserted on an ESCAPE_SYMBOL word. It is only ever on the final word of a pair or on a plain word.
- `escape_count` increments by 1 on each NORMAL accept with match and saturates at all-ones. If `clear_count` and an increment occur in the same cycle, `clear_count` wins (result 0).
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - state=NORMAL; pending data/tlast=0
  - escape_count=0
  - s_axis_tready=1 in the cycle after reset deasserts (output empty).
- Reset mid-operation discards any in-flight word and any pending second word; there is no partial-pair recovery.

## Timing
- Latency: input accept at edge N → word visible on m_axis at N+1.
- Throughput: 1 word/cycle for unescaped words with m_axis_tready held high. An escaped word occupies 2 output cycles, and s_axis_tready is low for exactly 1 cycle (the SECOND cycle) when the sink is always ready.
- AXI rule: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast are stable and m_axis_tvalid stays 1.
- No combinational path from s_axis_* to m_axis_*. The only combinational path is from m_axis_tready to s_axis_tready.
- escape_count updates at the accept edge, visible one cycle later.

## Test plan
- Defaults, sink always ready, input 01,D5,02 (tlast on 02) → output 01,E5,F5,02 with tlast on 02 only; s_axis_tready low exactly one cycle; escape_count=1.
- Input E5 with tlast=1 → output E5 (tlast=0), then C5 (tlast=1); next frame's first word follows with no bubble.
- Sink stalls 3 cycles while E5 is presented → m_axis_tdata stays E5, tvalid stays 1, s_axis_tready stays 0; after release, C5 follows, then input resumes.
- bypass=1, input D5,E5 → output D5,E5 unmodified with no stalls; escape_count unchanged. Toggling bypass during SECOND still emits F5.
- NUM_ESCAPED=3, list {D5,11,13}, COUNT_WIDTH=2, inputs 11,13,D5,E5,00 → output E5,31,E5,33,E5,F5,E5,C5,00; escape_count saturates at 3. Then clear_count asserted together with an escape → 0.
- areset asserted in SECOND → next cycle m_axis_tvalid=0, escape_count=0, pending F5 never emitted; s_axis_tready=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/stream_escape_encoder.sv
// stream_escape_encoder
// AXI-Stream byte-stuffing encoder for the Manchester TX path. A word that
// equals ESCAPE_SYMBOL or any ESCAPED_LIST entry leaves as the pair
// {ESCAPE_SYMBOL, data ^ XOR_MASK}. All other words pass through at one word
// per cycle. All m_axis outputs are registered. The only combinational path
// runs from m_axis_tready to s_axis_tready.
//
// Handshake: a transfer happens on a rising edge where tvalid && tready are
// both high. tvalid never waits for tready. Once m_axis_tvalid is high it
// stays high, and tdata/tlast stay stable, until the transfer completes.
// s_axis_tready does not depend on s_axis_tvalid.
module stream_escape_encoder #(
  parameter int                                  DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0]               ESCAPE_SYMBOL = 8'hE5,
  parameter int                                  NUM_ESCAPED   = 1,
  parameter logic [NUM_ESCAPED*DATA_WIDTH-1:0]   ESCAPED_LIST  = 8'hD5,
  parameter logic [DATA_WIDTH-1:0]               XOR_MASK      = 8'h20,
  parameter int                                  COUNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic                   bypass,
  input  logic                   clear_count,
  output logic [COUNT_WIDTH-1:0] escape_count
);

  // NORMAL: accepting input. SECOND: the escape marker is on the output, and
  // the mapped word waits in the pending register.
  typedef enum logic {
    NORMAL = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic                    pend_last_q, pend_last_d;
  logic [DATA_WIDTH-1:0]   tdata_d;
  logic                    tlast_d;
  logic                    tvalid_d;
  logic                    hit;
  logic                    match;
  logic                    out_free;
  logic                    accept;

  // Compare the input word against the marker and every list entry in parallel.
  always_comb begin
    hit = (s_axis_tdata == ESCAPE_SYMBOL);
    for (int i = 0; i < NUM_ESCAPED; i++) begin
      if (s_axis_tdata == ESCAPED_LIST[i*DATA_WIDTH +: DATA_WIDTH]) begin
        hit = 1'b1;
      end
    end
    match = !bypass && hit;
  end

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == NORMAL) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Compute the next state and the next contents of the output and pending registers.
  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;
    tdata_d     = m_axis_tdata;
    tlast_d     = m_axis_tlast;
    tvalid_d    = m_axis_tvalid;
    case (state_q)
      NORMAL: begin
        if (accept) begin
          tvalid_d = 1'b1;
          if (match) begin
            // The marker never carries tlast. The frame end moves to the mapped word.
            tdata_d     = ESCAPE_SYMBOL;
            tlast_d     = 1'b0;
            pend_data_d = s_axis_tdata ^ XOR_MASK;
            pend_last_d = s_axis_tlast;
            state_d     = SECOND;
          end else begin
            tdata_d = s_axis_tdata;
            tlast_d = s_axis_tlast;
          end
        end else if (m_axis_tready) begin
          tvalid_d = 1'b0;
        end
      end
      SECOND: begin
        if (m_axis_tready) begin
          tdata_d  = pend_data_q;
          tlast_d  = pend_last_q;
          tvalid_d = 1'b1;
          state_d  = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // State, output and pending registers. Reset drops any half-sent pair.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= NORMAL;
      pend_data_q   <= '0;
      pend_last_q   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_data_q   <= pend_data_d;
      pend_last_q   <= pend_last_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tvalid <= tvalid_d;
    end
  end

  // Saturating count of escape pairs. A clear wins over a simultaneous increment.
  always_ff @(posedge aclk) begin
    if (areset || clear_count) begin
      escape_count <= '0;
    end else if (accept && match && (escape_count != {COUNT_WIDTH{1'b1}})) begin
      escape_count <= escape_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stream_escape_encoder.sv
// tb_stream_escape_encoder
// Directed bench for stream_escape_encoder. dut1 uses the default parameters.
// dut2 uses a 3-entry list and a 2-bit counter. Each output handshake is
// checked against a queue of expected {tlast, data} words.
module tb_stream_escape_encoder;

  logic        aclk;
  logic        areset;

  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        bypass, clr;
  logic [15:0] cnt;

  logic [7:0]  s2_tdata;
  logic        s2_tvalid, s2_tready, s2_tlast;
  logic [7:0]  m2_tdata;
  logic        m2_tvalid, m2_tready, m2_tlast;
  logic        clr2;
  logic [1:0]  cnt2;

  logic [8:0]  exp_q[$];
  logic [8:0]  exp2_q[$];

  int total = 0;
  int bad   = 0;

  stream_escape_encoder dut1 (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .bypass        (bypass),
    .clear_count   (clr),
    .escape_count  (cnt)
  );

  stream_escape_encoder #(
    .NUM_ESCAPED  (3),
    .ESCAPED_LIST ({8'h13, 8'h11, 8'hD5}),
    .COUNT_WIDTH  (2)
  ) dut2 (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s2_tdata),
    .s_axis_tvalid (s2_tvalid),
    .s_axis_tready (s2_tready),
    .s_axis_tlast  (s2_tlast),
    .m_axis_tdata  (m2_tdata),
    .m_axis_tvalid (m2_tvalid),
    .m_axis_tready (m2_tready),
    .m_axis_tlast  (m2_tlast),
    .bypass        (1'b0),
    .clear_count   (clr2),
    .escape_count  (cnt2)
  );

  // Clock and watchdog
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check any handshakes on the falling edge, then move to just after the next rising edge.
  task automatic cyc;
    logic [8:0] e;
    @(negedge aclk);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("dut1_unexpected_word", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("dut1_out_word", {23'd0, m_tlast, m_tdata}, {23'd0, e});
      end
    end
    if (m2_tvalid && m2_tready) begin
      if (exp2_q.size() == 0) chk("dut2_unexpected_word", 32'(exp2_q.size()), 1);
      else begin
        e = exp2_q.pop_front();
        chk("dut2_out_word", {23'd0, m2_tlast, m2_tdata}, {23'd0, e});
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    #1;
  endtask

  task automatic idle;
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
    #1;
  endtask

  // Present one word to dut2 and hold it until it is accepted, within a cycle budget.
  task automatic send2(input logic [7:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    s2_tdata = d; s2_tlast = l; s2_tvalid = 1'b1;
    #1;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = s2_tready;
      cyc();
    end
    if (!acc) chk("dut2_accept_timeout", 32'(acc), 1);
    s2_tvalid = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    areset = 1'b1; m_tready = 1'b1; m2_tready = 1'b1;
    bypass = 1'b0; clr = 1'b0; clr2 = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    s2_tdata = 8'h00; s2_tvalid = 1'b0; s2_tlast = 1'b0;
    @(posedge aclk); #1;
    cyc(); cyc();
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_count", 32'(cnt), 0);
    areset = 1'b0;
    cyc();
    chk("post_rst_tready", 32'(s_tready), 1);

    // Frame 01,D5,02 with the sink always ready
    put(8'h01, 1'b0); exp_q.push_back({1'b0, 8'h01});
    chk("t1_tready_w0", 32'(s_tready), 1);
    cyc();
    chk("t1_latency_data", 32'(m_tdata), 32'h01);
    chk("t1_latency_valid", 32'(m_tvalid), 1);
    put(8'hD5, 1'b0); exp_q.push_back({1'b0, 8'hE5}); exp_q.push_back({1'b0, 8'hF5});
    cyc();
    chk("t1_esc_data", 32'(m_tdata), 32'hE5);
    chk("t1_esc_tlast", 32'(m_tlast), 0);
    put(8'h02, 1'b1);
    chk("t1_second_tready", 32'(s_tready), 0);
    cyc();
    chk("t1_mapped_data", 32'(m_tdata), 32'hF5);
    chk("t1_tready_back", 32'(s_tready), 1);
    exp_q.push_back({1'b1, 8'h02});
    cyc();
    chk("t1_last_data", 32'(m_tdata), 32'h02);
    chk("t1_last_tlast", 32'(m_tlast), 1);
    chk("t1_count", 32'(cnt), 1);
    idle(); cyc();
    chk("t1_drained", 32'(m_tvalid), 0);

    // E5 with tlast, then the next frame with no bubble
    put(8'hE5, 1'b1); exp_q.push_back({1'b0, 8'hE5}); exp_q.push_back({1'b1, 8'hC5});
    cyc();
    chk("t2_marker_tlast", 32'(m_tlast), 0);
    put(8'h07, 1'b0);
    chk("t2_second_tready", 32'(s_tready), 0);
    cyc();
    chk("t2_mapped_data", 32'(m_tdata), 32'hC5);
    chk("t2_mapped_tlast", 32'(m_tlast), 1);
    chk("t2_tready_back", 32'(s_tready), 1);
    exp_q.push_back({1'b0, 8'h07});
    cyc();
    chk("t2_no_bubble_valid", 32'(m_tvalid), 1);
    chk("t2_no_bubble_data", 32'(m_tdata), 32'h07);
    chk("t2_count", 32'(cnt), 2);
    idle(); cyc();

    // Sink stalls for 3 cycles while E5 is on the output
    put(8'hE5, 1'b0); exp_q.push_back({1'b0, 8'hE5}); exp_q.push_back({1'b0, 8'hC5});
    cyc();
    m_tready = 1'b0;
    put(8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_data", 32'(m_tdata), 32'hE5);
      chk("t3_stall_valid", 32'(m_tvalid), 1);
      chk("t3_stall_tready", 32'(s_tready), 0);
      cyc();
    end
    m_tready = 1'b1; #1;
    chk("t3_release_tready", 32'(s_tready), 0);
    cyc();
    chk("t3_mapped_data", 32'(m_tdata), 32'hC5);
    chk("t3_resume_tready", 32'(s_tready), 1);
    exp_q.push_back({1'b0, 8'h08});
    cyc();
    chk("t3_resume_data", 32'(m_tdata), 32'h08);
    idle(); cyc();
    chk("t3_count", 32'(cnt), 3);

    // Bypass passes D5 and E5 unchanged with no stall
    bypass = 1'b1;
    put(8'hD5, 1'b0); exp_q.push_back({1'b0, 8'hD5});
    cyc();
    chk("t4_byp_d5", 32'(m_tdata), 32'hD5);
    put(8'hE5, 1'b0); exp_q.push_back({1'b0, 8'hE5});
    chk("t4_byp_tready", 32'(s_tready), 1);
    cyc();
    chk("t4_byp_e5", 32'(m_tdata), 32'hE5);
    idle(); cyc();
    chk("t4_byp_count", 32'(cnt), 3);
    // Raising bypass during SECOND does not change the pending word
    bypass = 1'b0;
    put(8'hD5, 1'b1); exp_q.push_back({1'b0, 8'hE5}); exp_q.push_back({1'b1, 8'hF5});
    cyc();
    bypass = 1'b1; idle();
    cyc();
    chk("t4_toggle_data", 32'(m_tdata), 32'hF5);
    chk("t4_toggle_tlast", 32'(m_tlast), 1);
    bypass = 1'b0;
    cyc();
    chk("t4_toggle_count", 32'(cnt), 4);

    // dut2: 3-entry list and a 2-bit saturating counter
    exp2_q.push_back({1'b0, 8'hE5}); exp2_q.push_back({1'b0, 8'h31});
    exp2_q.push_back({1'b0, 8'hE5}); exp2_q.push_back({1'b0, 8'h33});
    exp2_q.push_back({1'b0, 8'hE5}); exp2_q.push_back({1'b0, 8'hF5});
    exp2_q.push_back({1'b0, 8'hE5}); exp2_q.push_back({1'b0, 8'hC5});
    exp2_q.push_back({1'b0, 8'h00});
    send2(8'h11, 1'b0);
    send2(8'h13, 1'b0);
    send2(8'hD5, 1'b0);
    chk("t5_count_three", 32'(cnt2), 3);
    send2(8'hE5, 1'b0);
    send2(8'h00, 1'b0);
    cyc(); cyc();
    chk("t5_count_saturated", 32'(cnt2), 3);
    // A clear in the same cycle as an escape accept wins
    s2_tdata = 8'h11; s2_tlast = 1'b0; s2_tvalid = 1'b1; clr2 = 1'b1;
    exp2_q.push_back({1'b0, 8'hE5}); exp2_q.push_back({1'b0, 8'h31});
    #1;
    chk("t5_clr_tready", 32'(s2_tready), 1);
    cyc();
    clr2 = 1'b0; s2_tvalid = 1'b0;
    chk("t5_clear_wins", 32'(cnt2), 0);
    cyc(); cyc();

    // Reset asserted while in SECOND
    put(8'hD5, 1'b0); exp_q.push_back({1'b0, 8'hE5});
    cyc();
    chk("t6_in_second", 32'(m_tdata), 32'hE5);
    areset = 1'b1; idle();
    cyc();
    chk("t6_rst_tvalid", 32'(m_tvalid), 0);
    chk("t6_rst_tdata", 32'(m_tdata), 0);
    chk("t6_rst_count", 32'(cnt), 0);
    areset = 1'b0;
    cyc();
    chk("t6_post_tready", 32'(s_tready), 1);
    chk("t6_no_pending", 32'(m_tvalid), 0);
    cyc(); cyc();
    chk("dut1_queue_empty", 32'(exp_q.size()), 0);
    chk("dut2_queue_empty", 32'(exp2_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
